sparse_buffer_alloc: RTL and testbench
======================================

Name: sparse_buffer_alloc

Overview:
Allocation/write side of the 8-entry sparse buffer. It allocates entries in order at a circular top pointer and stores a payload per entry. It releases entries out of order by index and exports the per-entry valid vector. The retire side computes the bottom pointer (oldest valid entry) from that vector by circular search upward from its current bottom pointer.

Parameters:
DEPTH, 8, number of entries; power of two.
PTR_W, 3, log2(DEPTH); width of pointers and indices.
DATA_W, 32, payload width per entry.

Ports:
clk_i  input  1  clock; all state changes on rising edge.
rst_ni  input  1  asynchronous active-low reset.
alloc_valid_i  input  1  allocation request.
alloc_ready_o  output  1  entry at top pointer is free; allocation accepted when valid&ready.
alloc_data_i  input  DATA_W  payload written on accepted allocation.
alloc_idx_o  output  PTR_W  index the current request will occupy (= top pointer).
dealloc_valid_i  input  1  release request.
dealloc_idx_i  input  PTR_W  entry to release.
dealloc_err_o  output  1  registered one-cycle pulse: previous-cycle release targeted a non-valid entry.
rd_idx_i  input  PTR_W  read index.
rd_data_o  output  DATA_W  combinational payload of entry rd_idx_i.
entry_valid_o  output  DEPTH  registered per-entry valid vector; feeds the bottom-pointer search.
top_ptr_o  output  PTR_W  registered top pointer.
count_o  output  PTR_W+1  number of valid entries, 0..DEPTH.
full_o  output  1  = !alloc_ready_o.
empty_o  output  1  count_o == 0.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - entry_valid=0, top_ptr=0, count=0, dealloc_err=0.
  - Hence alloc_ready_o=1, full_o=0, empty_o=1, alloc_idx_o=0.
  - The payload array is not reset. rd_data_o is defined only for indices that are valid.
- Reset asserted mid-operation clears all state immediately. Any request pending in that cycle is lost.
- alloc_ready_o = !entry_valid[top_ptr]. It is purely a function of registered state; there is no combinational path from dealloc_* or alloc_valid_i.
- Allocation fire (alloc_valid_i & alloc_ready_o):
  - entry_valid[top_ptr] <= 1.
  - data[top_ptr] <= alloc_data_i.
  - top_ptr <= top_ptr + 1, wrapping DEPTH-1 -> 0 by PTR_W truncation.
- Holes left by out-of-order release are not reused until the top pointer reaches them. Consequently:
  - full_o can be 1 while count_o < DEPTH.
  - full_o can be 0 while holes exist behind the top pointer.
- Release (dealloc_valid_i):
  - Checked against the pre-edge valid vector.
  - If entry_valid[idx]=1, clear it next edge.
  - Otherwise, no state change and dealloc_err_o=1 for exactly the following cycle.
  - Payload is not cleared.
- Same-cycle allocation and release:
  - Both apply.
  - Release of idx==top_ptr while that entry is valid frees it, but alloc_ready_o was already 0 this cycle. The allocation succeeds no earlier than the next cycle.
  - Release of idx==top_ptr while that entry is invalid is an error. A concurrent allocation into that entry still proceeds.
- count_o <= count_o + fire - release_ok. Net 0 on simultaneous fire and valid release. Never exceeds DEPTH; never underflows.
- Payload write-to-read: rd_data_o reflects new data starting the cycle after fire (no write-through bypass).
- alloc_valid_i held while not ready: no state change. Data may change while waiting; the value sampled at fire is stored.

Test Plan:
- Reset: after rst_ni deassert -> alloc_ready_o=1, full_o=0, empty_o=1, count_o=0, entry_valid_o=8'h00, top_ptr_o=0, dealloc_err_o=0.
- Fill and wrap: 8 back-to-back allocs with data 0xA0..0xA7 ->
  - alloc_idx_o 0..7 in sequence.
  - Then entry_valid_o=8'hFF, count_o=8, full_o=1, top_ptr_o=0.
  - rd_idx_i=5 -> rd_data_o=0xA5.
- Sparse hole: from full, release idx 3 ->
  - entry_valid_o=8'hF7, count_o=7, full_o still 1.
  - Release idx 0 -> next cycle alloc_ready_o=1.
  - Alloc 0x55 -> idx 0, entry_valid_o=8'hF7, top_ptr_o=1, full_o=1.
  - Idx 3 is still not reused.
- Invalid release: after reset, release idx 5 -> dealloc_err_o=1 for one cycle, then 0; count_o=0 and entry_valid_o=0 unchanged.
- Concurrency: with entries 0..2 valid and top_ptr_o=3, alloc 0x77 plus release idx 1 in the same cycle -> entry_valid_o=8'h0D, count_o=3, top_ptr_o=4.
- Async reset mid-stream: assert rst_ni low between edges with 6 entries valid -> all outputs return to reset values without waiting for a clock edge; first alloc after release goes to idx 0.

Source files
------------

// File: rtl/sparse_buffer_alloc_if.sv
// Allocation, release and read signals of the sparse buffer allocator.
// The slave modport is the allocator; the master modport is its user.
interface sparse_buffer_alloc_if #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int DATA_W = 32
);
  logic              alloc_valid_i;
  logic              alloc_ready_o;
  logic [DATA_W-1:0] alloc_data_i;
  logic [PTR_W-1:0]  alloc_idx_o;
  logic              dealloc_valid_i;
  logic [PTR_W-1:0]  dealloc_idx_i;
  logic              dealloc_err_o;
  logic [PTR_W-1:0]  rd_idx_i;
  logic [DATA_W-1:0] rd_data_o;
  logic [DEPTH-1:0]  entry_valid_o;
  logic [PTR_W-1:0]  top_ptr_o;
  logic [PTR_W:0]    count_o;
  logic              full_o;
  logic              empty_o;

  modport slave (
    input  alloc_valid_i, alloc_data_i, dealloc_valid_i, dealloc_idx_i, rd_idx_i,
    output alloc_ready_o, alloc_idx_o, dealloc_err_o, rd_data_o,
           entry_valid_o, top_ptr_o, count_o, full_o, empty_o
  );

  modport master (
    output alloc_valid_i, alloc_data_i, dealloc_valid_i, dealloc_idx_i, rd_idx_i,
    input  alloc_ready_o, alloc_idx_o, dealloc_err_o, rd_data_o,
           entry_valid_o, top_ptr_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/sparse_buffer_alloc.sv
// Sparse buffer allocation side: in-order allocation at a circular top pointer,
// out-of-order release by index, per-entry payload storage and valid vector export.
module sparse_buffer_alloc #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  sparse_buffer_alloc_if.slave bus
);

  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_top;
  logic [PTR_W:0]    r_count;
  logic              r_err;
  logic [DATA_W-1:0] r_data [DEPTH];

  logic              w_ready;
  logic              w_fire;
  logic              w_rel_ok;
  logic              w_rel_bad;
  logic [DEPTH-1:0]  w_valid_next;
  logic [PTR_W:0]    w_count_next;

  // Ready depends only on registered state, so a same-cycle release never unblocks allocation.
  assign w_ready   = ~r_valid[r_top];
  assign w_fire    = bus.alloc_valid_i & w_ready;
  assign w_rel_ok  = bus.dealloc_valid_i & r_valid[bus.dealloc_idx_i];
  assign w_rel_bad = bus.dealloc_valid_i & ~r_valid[bus.dealloc_idx_i];

  // Fire needs the entry free and a good release needs it valid, so both can never hit one bit.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid_next
    always_comb begin
      w_valid_next[gi] = r_valid[gi];
      if (w_fire && (r_top == PTR_W'(gi))) begin
        w_valid_next[gi] = 1'b1;
      end
      if (w_rel_ok && (bus.dealloc_idx_i == PTR_W'(gi))) begin
        w_valid_next[gi] = 1'b0;
      end
    end
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_fire, w_rel_ok})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_top   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_valid_next;
      r_count <= w_count_next;
      r_err   <= w_rel_bad;
      if (w_fire) begin
        r_top <= r_top + PTR_ONE;
      end
    end
  end

  // Payload storage is deliberately left out of reset; readers only trust valid entries.
  always_ff @(posedge clk_i) begin
    if (w_fire) begin
      r_data[r_top] <= bus.alloc_data_i;
    end
  end

  assign bus.alloc_ready_o = w_ready;
  assign bus.alloc_idx_o   = r_top;
  assign bus.dealloc_err_o = r_err;
  assign bus.rd_data_o     = r_data[bus.rd_idx_i];
  assign bus.entry_valid_o = r_valid;
  assign bus.top_ptr_o     = r_top;
  assign bus.count_o       = r_count;
  assign bus.full_o        = ~w_ready;
  assign bus.empty_o       = (r_count == '0);

endmodule

// File: tb/tb_sparse_buffer_alloc.sv
// Self-checking bench for sparse_buffer_alloc: directed scenarios followed by
// random traffic, all compared against an array-based reference model.
module tb_sparse_buffer_alloc;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int DATA_W = 32;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  sparse_buffer_alloc_if #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DATA_W)) bus ();

  sparse_buffer_alloc #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DATA_W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: per-entry flags and payloads, a wrapping top pointer, last error flag.
  bit                m_valid [DEPTH];
  logic [DATA_W-1:0] m_data  [DEPTH];
  logic [PTR_W-1:0]  m_top;
  bit                m_err;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DEPTH-1:0] m_vec();
    logic [DEPTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic int m_count();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_top = '0;
    m_err = 1'b0;
  endtask

  task automatic check_regs(input string pfx);
    check_eq({pfx, ".entry_valid"}, bus.entry_valid_o, m_vec());
    check_eq({pfx, ".top_ptr"},     bus.top_ptr_o, m_top);
    check_eq({pfx, ".count"},       bus.count_o, m_count());
    check_eq({pfx, ".empty"},       bus.empty_o, m_count() == 0);
    check_eq({pfx, ".full"},        bus.full_o, m_valid[m_top]);
    check_eq({pfx, ".ready"},       bus.alloc_ready_o, !m_valid[m_top]);
    check_eq({pfx, ".dealloc_err"}, bus.dealloc_err_o, m_err);
  endtask

  // One clock of traffic: combinational checks before the edge, registered checks after it.
  task automatic do_cycle(input bit av, input logic [DATA_W-1:0] ad, input bit dv,
                          input logic [PTR_W-1:0] di, input logic [PTR_W-1:0] ri);
    bit ready, fire, rel_ok;
    bus.alloc_valid_i   = av;
    bus.alloc_data_i    = ad;
    bus.dealloc_valid_i = dv;
    bus.dealloc_idx_i   = di;
    bus.rd_idx_i        = ri;
    #1;
    ready = !m_valid[m_top];
    check_eq("alloc_ready", bus.alloc_ready_o, ready);
    check_eq("alloc_idx", bus.alloc_idx_o, m_top);
    if (m_valid[ri]) check_eq("rd_data", bus.rd_data_o, m_data[ri]);
    fire   = av && ready;
    rel_ok = dv && m_valid[di];
    @(posedge clk_i);
    m_err = dv && !m_valid[di];
    if (rel_ok) m_valid[di] = 1'b0;
    if (fire) begin
      m_valid[m_top] = 1'b1;
      m_data[m_top]  = ad;
      m_top          = m_top + 1'b1;
    end
    #1;
    check_regs("post");
  endtask

  task automatic idle_inputs();
    bus.alloc_valid_i   = 1'b0;
    bus.alloc_data_i    = '0;
    bus.dealloc_valid_i = 1'b0;
    bus.dealloc_idx_i   = '0;
    bus.rd_idx_i        = '0;
  endtask

  // Pulls reset low between edges and checks the outputs clear before any clock edge.
  task automatic async_reset();
    idle_inputs();
    #2;
    rst_ni = 1'b0;
    #1;
    m_reset();
    check_regs("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_regs("after_rst");
  endtask

  initial begin
    logic [PTR_W-1:0] ri;
    idle_inputs();
    m_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_regs("reset");
    check_eq("reset.entry_valid_const", bus.entry_valid_o, 8'h00);
    check_eq("reset.ready_const", bus.alloc_ready_o, 1'b1);

    // Fill and wrap
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("fill.idx_seq", bus.alloc_idx_o, i);
      do_cycle(1'b1, DATA_W'(32'hA0 + i), 1'b0, '0, '0);
    end
    check_eq("fill.entry_valid", bus.entry_valid_o, 8'hFF);
    check_eq("fill.count", bus.count_o, 8);
    check_eq("fill.full", bus.full_o, 1'b1);
    check_eq("fill.top", bus.top_ptr_o, 0);
    do_cycle(1'b0, '0, 1'b0, '0, 3'd5);
    check_eq("fill.rd5", bus.rd_data_o, 32'hA5);

    // Sparse hole: releasing idx 3 does not make room at the top pointer
    do_cycle(1'b0, '0, 1'b1, 3'd3, '0);
    check_eq("hole.entry_valid", bus.entry_valid_o, 8'hF7);
    check_eq("hole.count", bus.count_o, 7);
    check_eq("hole.full", bus.full_o, 1'b1);
    do_cycle(1'b0, '0, 1'b1, 3'd0, '0);
    check_eq("hole.ready_after_rel0", bus.alloc_ready_o, 1'b1);
    do_cycle(1'b1, 32'h55, 1'b0, '0, '0);
    check_eq("hole.entry_valid2", bus.entry_valid_o, 8'hF7);
    check_eq("hole.top", bus.top_ptr_o, 1);
    check_eq("hole.full2", bus.full_o, 1'b1);
    do_cycle(1'b0, '0, 1'b0, '0, 3'd0);
    check_eq("hole.rd0", bus.rd_data_o, 32'h55);

    // Invalid release from empty
    async_reset();
    do_cycle(1'b0, '0, 1'b1, 3'd5, '0);
    check_eq("badrel.err", bus.dealloc_err_o, 1'b1);
    check_eq("badrel.count", bus.count_o, 0);
    check_eq("badrel.entry_valid", bus.entry_valid_o, 8'h00);
    do_cycle(1'b0, '0, 1'b0, '0, '0);
    check_eq("badrel.err_clear", bus.dealloc_err_o, 1'b0);

    // Concurrent alloc and release
    for (int i = 0; i < 3; i++) do_cycle(1'b1, DATA_W'(32'h10 + i), 1'b0, '0, '0);
    do_cycle(1'b1, 32'h77, 1'b1, 3'd1, '0);
    check_eq("conc.entry_valid", bus.entry_valid_o, 8'h0D);
    check_eq("conc.count", bus.count_o, 3);
    check_eq("conc.top", bus.top_ptr_o, 4);

    // Async reset mid-stream with 6 entries valid
    async_reset();
    for (int i = 0; i < 6; i++) do_cycle(1'b1, DATA_W'(32'hC0 + i), 1'b0, '0, '0);
    check_eq("midrst.count_before", bus.count_o, 6);
    async_reset();
    check_eq("midrst.entry_valid", bus.entry_valid_o, 8'h00);
    check_eq("midrst.first_idx", bus.alloc_idx_o, 0);
    do_cycle(1'b1, 32'hE0, 1'b0, '0, '0);
    check_eq("midrst.top", bus.top_ptr_o, 1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      ri = PTR_W'($urandom_range(0, DEPTH - 1));
      do_cycle(1'($urandom_range(0, 2) != 0), DATA_W'($urandom),
               1'($urandom_range(0, 1)), PTR_W'($urandom_range(0, DEPTH - 1)), ri);
      if (n == 300) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
